// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-port ALU arbiter.
// Widths, FSM state encoding, the op bundle and reference opcodes.
package alu_arbiter_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int OPCODE_SIZE = 4;

  typedef logic [WORD_SIZE-1:0]   word_t;
  typedef logic [OPCODE_SIZE-1:0] opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EXEC,
    S_CAPTURE,
    S_RESPOND
  } state_t;

  typedef struct packed {
    opcode_t opcode;
    word_t   a;
    word_t   b;
  } alu_op_t;

  localparam opcode_t OP_ADD = 4'd0;
  localparam opcode_t OP_SUB = 4'd1;
  localparam opcode_t OP_AND = 4'd2;
  localparam opcode_t OP_OR  = 4'd3;
  localparam opcode_t OP_XOR = 4'd4;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester port: request valid/ready with opcode and operands,
// response valid/ready with result. master = requester, slave = arbiter.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic    valid;
  logic    ready;
  opcode_t opcode;
  word_t   a;
  word_t   b;
  logic    resp_valid;
  logic    resp_ready;
  word_t   resp_data;

  modport master (
    output valid, opcode, a, b, resp_ready,
    input  ready, resp_valid, resp_data
  );

  modport slave (
    input  valid, opcode, a, b, resp_ready,
    output ready, resp_valid, resp_data
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant: req[1:0], ptr (favoured side), grant[1:0].
// Purely combinational; a lone requester wins regardless of ptr.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = ptr ? 2'b10 : 2'b01;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, one op at a time.
// Ports: clock, reset, req0/req1 (slave), alu_* to ALU, alu_out, busy.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  alu_arbiter_if.slave  req0,
  alu_arbiter_if.slave  req1,
  output opcode_t       alu_opcode,
  output word_t         alu_input1,
  output word_t         alu_input2,
  output logic          alu_enable,
  input  word_t         alu_out,
  output logic          busy
);

  state_t     state;
  state_t     state_n;
  logic       ptr;
  logic       owner;
  word_t      result_reg;
  logic [1:0] req_v;
  logic [1:0] grant;
  logic       accept;
  logic       done;
  alu_op_t    win_op;

  assign req_v = {req1.valid, req0.valid};

  rr_arbiter_2 u_rr (
    .req   (req_v),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req0.ready = (state == S_IDLE) & grant[0];
  assign req1.ready = (state == S_IDLE) & grant[1];

  assign accept = (req0.valid & req0.ready)
                | (req1.valid & req1.ready);

  assign done = (state == S_RESPOND)
              & (owner ? req1.resp_ready
                       : req0.resp_ready);

  assign win_op = grant[1]
    ? '{opcode: req1.opcode, a: req1.a, b: req1.b}
    : '{opcode: req0.opcode, a: req0.a, b: req0.b};

  assign req0.resp_data = result_reg;
  assign req1.resp_data = result_reg;

  always_comb begin
    state_n         = state;
    alu_enable      = 1'b0;
    busy            = 1'b1;
    req0.resp_valid = 1'b0;
    req1.resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (accept) state_n = S_SETUP;
      end
      S_SETUP:   state_n = S_EXEC;
      S_EXEC: begin
        alu_enable = 1'b1;
        state_n    = S_CAPTURE;
      end
      S_CAPTURE: state_n = S_RESPOND;
      S_RESPOND: begin
        req0.resp_valid = ~owner;
        req1.resp_valid = owner;
        if (done) state_n = S_IDLE;
      end
      default:   state_n = S_IDLE;
    endcase
  end

  // The alu_* registers double as the op latch, so they hold the
  // last issued op while idle and cannot move mid-operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      result_reg <= '0;
      alu_opcode <= '0;
      alu_input1 <= '0;
      alu_input2 <= '0;
    end else begin
      state <= state_n;
      if ((state == S_IDLE) && accept) begin
        owner      <= grant[1];
        alu_opcode <= win_op.opcode;
        alu_input1 <= win_op.a;
        alu_input2 <= win_op.b;
      end
      if (state == S_CAPTURE) result_reg <= alu_out;
      if (done) ptr <= ~owner;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU stand-in.
// Directed spec scenarios followed by randomized two-port traffic.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic    clock = 1'b0;
  logic    reset = 1'b1;
  opcode_t alu_opcode;
  word_t   alu_input1;
  word_t   alu_input2;
  logic    alu_enable;
  word_t   alu_out = '0;
  logic    busy;

  alu_arbiter_if r0 ();
  alu_arbiter_if r1 ();

  alu_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req0       (r0.slave),
    .req1       (r1.slave),
    .alu_opcode (alu_opcode),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_enable (alu_enable),
    .alu_out    (alu_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic word_t ref_alu(opcode_t op, word_t a, word_t b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Registered ALU: result appears after the enabled edge.
  always @(posedge clock)
    if (alu_enable) alu_out <= ref_alu(alu_opcode, alu_input1, alu_input2);

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clock) cyc++;

  // Response ready: random or forced low per port.
  bit hold_low0 = 0;
  bit hold_low1 = 0;
  bit rand_rdy  = 0;
  always @(posedge clock) begin
    #1;
    r0.resp_ready = hold_low0 ? 1'b0 : (rand_rdy ? ($urandom % 3 != 0) : 1'b1);
    r1.resp_ready = hold_low1 ? 1'b0 : (rand_rdy ? ($urandom % 3 != 0) : 1'b1);
  end

  // Reference model state: at most one op in flight.
  bit         outstanding = 0;
  bit         was_out;
  bit         own = 0;
  bit         mptr = 0;
  int         acc_cyc = 0;
  int         acc_cnt = 0;
  int         done_cnt [2] = '{0, 0};
  word_t      last_data [2] = '{16'h0, 16'h0};
  opcode_t    m_op;
  word_t      m_a;
  word_t      m_b;
  word_t      q0 [$];
  word_t      q1 [$];
  logic [1:0] v;
  logic [1:0] erdy;
  logic [1:0] evld;

  always @(negedge clock) begin
    if (reset) begin
      outstanding = 0;
      mptr = 0;
      q0.delete();
      q1.delete();
    end else begin
      was_out = outstanding;
      v = {r1.valid, r0.valid};
      erdy = 2'b00;
      if (!was_out) erdy = (v == 2'b11) ? (mptr ? 2'b10 : 2'b01) : v;
      check("req_ready", 64'({r1.ready, r0.ready}), 64'(erdy));
      check("busy", 64'(busy), 64'(was_out));
      check("alu_enable", 64'(alu_enable),
            64'(was_out && (cyc == acc_cyc + 2)));
      if (was_out && cyc > acc_cyc && cyc < acc_cyc + 4)
        check("alu_operands",
              64'({alu_opcode, alu_input1, alu_input2}),
              64'({m_op, m_a, m_b}));
      evld = 2'b00;
      if (was_out && cyc >= acc_cyc + 4) evld[own] = 1'b1;
      check("resp_valid", 64'({r1.resp_valid, r0.resp_valid}), 64'(evld));
      if (evld[0] && r0.resp_valid && q0.size() > 0) begin
        check("resp0_data", 64'(r0.resp_data), 64'(q0[0]));
        if (r0.resp_ready) begin
          last_data[0] = r0.resp_data;
          void'(q0.pop_front());
          done_cnt[0]++;
          outstanding = 0;
          mptr = 1;
        end
      end
      if (evld[1] && r1.resp_valid && q1.size() > 0) begin
        check("resp1_data", 64'(r1.resp_data), 64'(q1[0]));
        if (r1.resp_ready) begin
          last_data[1] = r1.resp_data;
          void'(q1.pop_front());
          done_cnt[1]++;
          outstanding = 0;
          mptr = 0;
        end
      end
      if (!was_out && erdy != 2'b00) begin
        own  = erdy[1];
        m_op = own ? r1.opcode : r0.opcode;
        m_a  = own ? r1.a : r0.a;
        m_b  = own ? r1.b : r0.b;
        if (own) q1.push_back(ref_alu(m_op, m_a, m_b));
        else     q0.push_back(ref_alu(m_op, m_a, m_b));
        acc_cnt++;
        outstanding = 1;
        acc_cyc = cyc;
      end
    end
  end

  task automatic drive(int p, bit vld, opcode_t op, word_t a, word_t b);
    if (p == 0) begin
      r0.valid = vld; r0.opcode = op; r0.a = a; r0.b = b;
    end else begin
      r1.valid = vld; r1.opcode = op; r1.a = a; r1.b = b;
    end
  endtask

  // Holds valid until accepted; a tentative request gives up after one cycle.
  task automatic do_req(int p, opcode_t op, word_t a, word_t b, bit tentative);
    bit got = 0;
    @(posedge clock);
    #1 drive(p, 1'b1, op, a, b);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      got = (p == 0) ? r0.ready : r1.ready;
      if (!got && tentative) break;
    end
    if (!got && !tentative) begin
      checks++;
      errors++;
      $display("FAIL req%0d_accept_timeout: got no ready expected ready", p);
    end
    @(posedge clock);
    #1 drive(p, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int i = 0; i < 80 && !idle; i++) begin
      @(negedge clock);
      #1 idle = !outstanding;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy expected idle");
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic rand_port(int p, int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clock);
      do_req(p, opcode_t'($urandom), word_t'($urandom),
             word_t'($urandom), ($urandom % 4) == 0);
    end
  endtask

  word_t stall_data;
  bit    seen;
  int    d0;

  initial begin
    drive(0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0);
    r0.resp_ready = 1'b1;
    r1.resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_enable", 64'(alu_enable), 64'd0);
    check("rst_resp_valid", 64'({r1.resp_valid, r0.resp_valid}), 64'd0);
    check("rst_alu_regs", 64'({alu_opcode, alu_input1, alu_input2}), 64'd0);
    check("rst_resp_data", 64'({r1.resp_data, r0.resp_data}), 64'd0);

    // Lone ADD on port 0.
    do_req(0, OP_ADD, 16'h0003, 16'h0004, 1'b0);
    wait_idle();
    check("t1_result", 64'(last_data[0]), 64'h0007);
    check("t1_no_resp1", 64'(done_cnt[1]), 64'd0);

    // Both valid after reset: port 0 first, then port 1.
    do_reset();
    fork
      do_req(0, OP_SUB, 16'h0005, 16'h0007, 1'b0);
      do_req(1, OP_XOR, 16'h00FF, 16'h0F0F, 1'b0);
    join
    wait_idle();
    check("t2_result0", 64'(last_data[0]), 64'hFFFE);
    check("t2_result1", 64'(last_data[1]), 64'h0FF0);

    // Port 1 alone with pointer at 0.
    do_req(1, OP_AND, 16'hF0F0, 16'h3C3C, 1'b0);
    wait_idle();
    check("t6_result1", 64'(last_data[1]), 64'h3030);

    // Back-to-back on port 0.
    do_req(0, OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
    do_req(0, OP_ADD, 16'h8000, 16'h7FFF, 1'b0);
    wait_idle();
    check("t3_result0", 64'(last_data[0]), 64'hFFFF);

    // Response stalled for 10 cycles.
    hold_low1 = 1;
    do_req(1, OP_OR, 16'h1234, 16'h00F0, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = r1.resp_valid;
    end
    check("t4_resp_seen", 64'(seen), 64'd1);
    stall_data = r1.resp_data;
    repeat (10) begin
      @(negedge clock);
      #1;
      check("t4_valid_held", 64'(r1.resp_valid), 64'd1);
      check("t4_data_held", 64'(r1.resp_data), 64'(stall_data));
      check("t4_busy", 64'(busy), 64'd1);
    end
    hold_low1 = 0;
    wait_idle();
    check("t4_result1", 64'(last_data[1]), 64'h12F4);

    // Randomized traffic on both ports.
    rand_rdy = 1;
    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join
    wait_idle();
    rand_rdy = 0;
    check("rand_all_done", 64'(done_cnt[0] + done_cnt[1]), 64'(acc_cnt));

    // Reset during EXEC drops the op; pointer returns to 0.
    do_req(0, OP_ADD, 16'h0001, 16'h0001, 1'b0);
    wait_idle();
    d0 = done_cnt[0];
    do_req(0, OP_XOR, 16'hAAAA, 16'h5555, 1'b0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = alu_enable;
    end
    check("t5_exec_seen", 64'(seen), 64'd1);
    #1 reset = 1'b1;
    @(negedge clock);
    #2;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_alu_enable", 64'(alu_enable), 64'd0);
    check("t5_resp_valid", 64'({r1.resp_valid, r0.resp_valid}), 64'd0);
    check("t5_alu_regs", 64'({alu_opcode, alu_input1, alu_input2}), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    fork
      do_req(0, OP_ADD, 16'h0010, 16'h0020, 1'b0);
      do_req(1, OP_SUB, 16'h0010, 16'h0001, 1'b0);
    join
    wait_idle();
    check("t5_dropped", 64'(done_cnt[0]), 64'(d0 + 1));
    check("t5_result0", 64'(last_data[0]), 64'h0030);
    check("t5_result1", 64'(last_data[1]), 64'h000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
